// File: rtl/hyperram_axil_slave_bridge_if.sv
// ---------------------------------------------------------------------------
// hyperram_axil_slave_bridge_if
// Bundles the AXI4-Lite slave channels and the word-command channel toward
// the HyperRAM controller.
//   slave  modport : the bridge's view (AXI slave, command master)
//   master modport : the view of the AXI master plus the controller
// Signals:
//   AW/W/B  : awaddr, awvalid, awready, wdata, wvalid, wready, bresp, bvalid, bready
//   AR/R    : araddr, arvalid, arready, rdata, rresp, rvalid, rready
//   command : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   response: rsp_valid, rsp_rdata
// ---------------------------------------------------------------------------
interface hyperram_axil_slave_bridge_if #(
    parameter int ADDR_BITS = 23
) ();
    logic [31:0]          awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [31:0]          araddr;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
               cmd_ready, rsp_valid, rsp_rdata,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
               cmd_ready, rsp_valid, rsp_rdata,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/hyperram_axil_slave_bridge.sv
// ---------------------------------------------------------------------------
// hyperram_axil_slave_bridge
// AXI4-Lite slave that turns each single-beat transaction into one word
// command toward the HyperRAM controller and returns the B/R response.
// One transaction outstanding at a time; address checking, response timeout
// and read/write alternation when both directions compete.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : AXI4-Lite AW/W/B/AR/R plus cmd/rsp channel
//   o_busy            : high whenever the bridge is not idle
//   o_timeout_count   : saturating count of timed-out commands
// ---------------------------------------------------------------------------
module hyperram_axil_slave_bridge #(
    parameter int ADDR_BITS = 23,
    parameter int TIMEOUT   = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    hyperram_axil_slave_bridge_if.slave   bus,
    output logic                          o_busy,
    output logic [15:0]                   o_timeout_count
);

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WCAP     = 3'd1,
        S_CMD      = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_BRESP    = 3'd4,
        S_RRESP    = 3'd5
    } state_t;

    // Misaligned wins over out-of-range when both apply.
    function automatic logic [1:0] addr_check(input logic [31:0] addr);
        logic [31:0] hi;
        logic [1:0]  resp;
        hi = addr >> ADDR_BITS;
        if (addr[1:0] != 2'b00) begin
            resp = RESP_SLVERR;
        end else if (hi != 32'd0) begin
            resp = RESP_DECERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

    state_t                r_state;
    logic                  r_busy;
    logic                  r_aw_have;
    logic                  r_w_have;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_last_was_write;
    logic                  r_drop_rsp;
    logic [15:0]           r_timer;
    logic [15:0]           r_timeout_count;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [31:0]           r_rdata;
    logic                  r_cmd_valid;
    logic                  r_cmd_write;
    logic [ADDR_BITS-1:0]  r_cmd_addr;
    logic [31:0]           r_cmd_wdata;

    logic                  w_idle;
    logic                  w_wcap;
    logic                  w_wr_want;
    logic                  w_rd_want;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_go_cmd;
    logic                  w_tgt_write;
    logic [31:0]           w_tgt_addr;
    logic [31:0]           w_tgt_wdata;
    logic [1:0]            w_tgt_resp;

    assign w_idle = (r_state == S_IDLE);
    assign w_wcap = (r_state == S_WCAP);

    // A pending late response must be swallowed before new work is granted.
    assign w_wr_want  = (bus.awvalid | bus.wvalid) & ~r_drop_rsp;
    assign w_rd_want  = bus.arvalid & ~r_drop_rsp;
    assign w_grant_wr = w_wr_want & (~w_rd_want | ~r_last_was_write);
    assign w_grant_rd = w_rd_want & ~w_grant_wr;

    assign bus.awready = (w_idle & w_grant_wr) | (w_wcap & ~r_aw_have);
    assign bus.wready  = (w_idle & w_grant_wr) | (w_wcap & ~r_w_have);
    assign bus.arready = w_idle & w_grant_rd;

    assign w_aw_hs = bus.awvalid & bus.awready;
    assign w_w_hs  = bus.wvalid & bus.wready;
    assign w_ar_hs = bus.arvalid & bus.arready;

    // Enter CMD on a read grant, or once both write halves are (or become) held.
    assign w_go_cmd = w_ar_hs |
                      ((w_idle | w_wcap) & (r_aw_have | w_aw_hs) & (r_w_have | w_w_hs));

    // Select the address/data the transaction will carry into CMD this cycle.
    always_comb begin
        w_tgt_write = 1'b1;
        w_tgt_addr  = r_addr;
        w_tgt_wdata = r_wdata;
        if (w_ar_hs) begin
            w_tgt_write = 1'b0;
            w_tgt_addr  = bus.araddr;
            w_tgt_wdata = 32'd0;
        end else begin
            if (w_aw_hs) begin
                w_tgt_addr = bus.awaddr;
            end else begin
                w_tgt_addr = r_addr;
            end
            if (w_w_hs) begin
                w_tgt_wdata = bus.wdata;
            end else begin
                w_tgt_wdata = r_wdata;
            end
        end
        w_tgt_resp = addr_check(w_tgt_addr);
    end

    // Main transaction FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_aw_have        <= 1'b0;
            r_w_have         <= 1'b0;
            r_addr           <= 32'd0;
            r_wdata          <= 32'd0;
            r_last_was_write <= 1'b0;
            r_drop_rsp       <= 1'b0;
            r_timer          <= 16'd0;
            r_timeout_count  <= 16'd0;
            r_bvalid         <= 1'b0;
            r_bresp          <= 2'b00;
            r_rvalid         <= 1'b0;
            r_rresp          <= 2'b00;
            r_rdata          <= 32'd0;
            r_cmd_valid      <= 1'b0;
            r_cmd_write      <= 1'b0;
            r_cmd_addr       <= '0;
            r_cmd_wdata      <= 32'd0;
        end else begin
            // Stale completion from a timed-out command: consume it here.
            if (r_drop_rsp && bus.rsp_valid) begin
                r_drop_rsp <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_WCAP: begin
                    if (w_aw_hs) begin
                        r_addr    <= bus.awaddr;
                        r_aw_have <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= bus.wdata;
                        r_w_have <= 1'b1;
                    end
                    if (w_idle && w_grant_rd) begin
                        r_last_was_write <= 1'b0;
                    end else if (w_idle && w_grant_wr) begin
                        r_last_was_write <= 1'b1;
                    end
                    if (w_go_cmd) begin
                        r_aw_have <= 1'b0;
                        r_w_have  <= 1'b0;
                        r_busy    <= 1'b1;
                        if (w_tgt_resp != RESP_OKAY) begin
                            // Rejected address: answer without touching the controller.
                            if (w_tgt_write) begin
                                r_state  <= S_BRESP;
                                r_bvalid <= 1'b1;
                                r_bresp  <= w_tgt_resp;
                            end else begin
                                r_state  <= S_RRESP;
                                r_rvalid <= 1'b1;
                                r_rresp  <= w_tgt_resp;
                                r_rdata  <= 32'd0;
                            end
                        end else begin
                            r_state     <= S_CMD;
                            r_cmd_valid <= 1'b1;
                            r_cmd_write <= w_tgt_write;
                            r_cmd_addr  <= w_tgt_addr[ADDR_BITS-1:0];
                            r_cmd_wdata <= w_tgt_wdata;
                        end
                    end else if (w_idle && w_grant_wr) begin
                        r_state <= S_WCAP;
                        r_busy  <= 1'b1;
                    end
                end

                S_CMD: begin
                    if (bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT_RSP;
                        r_timer     <= 16'd0;
                    end
                end

                S_WAIT_RSP: begin
                    if (bus.rsp_valid) begin
                        if (r_cmd_write) begin
                            r_state  <= S_BRESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_OKAY;
                        end else begin
                            r_state  <= S_RRESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_OKAY;
                            r_rdata  <= bus.rsp_rdata;
                        end
                    end else if (r_timer >= TIMEOUT_LAST) begin
                        // Give up; the controller's eventual completion is dropped.
                        r_drop_rsp <= 1'b1;
                        if (r_timeout_count != 16'hFFFF) begin
                            r_timeout_count <= r_timeout_count + 16'd1;
                        end
                        if (r_cmd_write) begin
                            r_state  <= S_BRESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end else begin
                            r_state  <= S_RRESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_SLVERR;
                            r_rdata  <= 32'hDEAD_BEEF;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_BRESP: begin
                    if (bus.bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                S_RRESP: begin
                    if (bus.rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_bvalid    <= 1'b0;
                    r_rvalid    <= 1'b0;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bvalid    = r_bvalid;
    assign bus.bresp     = r_bresp;
    assign bus.rvalid    = r_rvalid;
    assign bus.rresp     = r_rresp;
    assign bus.rdata     = r_rdata;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_write = r_cmd_write;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.cmd_wdata = r_cmd_wdata;
    assign o_busy          = r_busy;
    assign o_timeout_count = r_timeout_count;

endmodule

// File: tb/tb_hyperram_axil_slave_bridge.sv
module tb_hyperram_axil_slave_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] tcount;

    always #5 clk = ~clk;

    hyperram_axil_slave_bridge_if #(.ADDR_BITS(23)) bus ();

    hyperram_axil_slave_bridge #(.ADDR_BITS(23), .TIMEOUT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .o_busy          (busy),
        .o_timeout_count (tcount)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [22:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Controller model state (written only by the controller process)
    cmd_t        cmd_log[$];
    logic [31:0] ctl_mem[logic [22:0]];
    int          ctl_cnt = 0;
    logic [31:0] ctl_pend = 32'd0;
    int          inject_done = 0;

    // Controller knobs (written only by the test sequence)
    int          ctl_delay = 1;
    bit          ctl_respond = 1'b1;
    bit          ctl_force = 1'b0;
    logic [31:0] ctl_force_data = 32'd0;
    int          inject_req = 0;

    // Reference memory: what a read of an in-range word should return
    logic [31:0] ref_mem[logic [31:0]];

    // HyperRAM controller model: logs accepted commands, answers after ctl_delay cycles
    initial begin
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = ctl_pend;
                end
            end
            if (inject_req != inject_done) begin
                inject_done++;
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = 32'h0BAD_0BAD;
            end
            if (bus.cmd_valid && bus.cmd_ready && !reset) begin
                cmd_log.push_back('{bus.cmd_write, bus.cmd_addr, bus.cmd_wdata});
                if (bus.cmd_write) ctl_mem[bus.cmd_addr] = bus.cmd_wdata;
                if (ctl_force) ctl_pend = ctl_force_data;
                else if (ctl_mem.exists(bus.cmd_addr)) ctl_pend = ctl_mem[bus.cmd_addr];
                else ctl_pend = ~{9'd0, bus.cmd_addr};
                if (ctl_respond) ctl_cnt = ctl_delay;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        if (addr % 4 != 0) return 2'b10;
        if (addr >= 32'h0080_0000) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        if (ref_mem.exists(addr)) return ref_mem[addr];
        return ~addr;
    endfunction

    // AXI write master: AW/W launched after independent delays, B accepted after b_dly
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat, output bit ok);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        int cyc = 0;
        int n = 0;
        int hold = 0;
        bus.awaddr = addr;
        bus.wdata  = data;
        lat  = -1;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            bus.awvalid = !aw_done && cyc >= aw_dly;
            bus.wvalid  = !w_done && cyc >= w_dly;
            #1;
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready) w_done = 1'b1;
            cyc++;
        end
        ok = 1'b0;
        if (aw_done && w_done) begin
            while (!ok && n < 100) begin
                @(negedge clk);
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                n++;
                if (bus.bvalid) begin
                    if (lat < 0) begin
                        lat  = n;
                        resp = bus.bresp;
                    end
                    if (hold >= b_dly) begin
                        bus.bready = 1'b1;
                        ok = 1'b1;
                    end else hold++;
                end
            end
            @(negedge clk);
            bus.bready = 1'b0;
        end else begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
    endtask

    // AXI read master: AR after ar_dly, R accepted after r_dly, R held stable meanwhile
    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [1:0] resp, output logic [31:0] data,
                           output int lat, output bit ok, output bit stable);
        bit ar_done = 1'b0;
        int cyc = 0;
        int n = 0;
        int hold = 0;
        bus.araddr = addr;
        stable = 1'b1;
        lat  = -1;
        resp = 2'bxx;
        data = 32'hxxxx_xxxx;
        while (!ar_done && cyc < 100) begin
            @(negedge clk);
            bus.arvalid = cyc >= ar_dly;
            #1;
            if (bus.arvalid && bus.arready) ar_done = 1'b1;
            cyc++;
        end
        ok = 1'b0;
        if (ar_done) begin
            while (!ok && n < 100) begin
                @(negedge clk);
                bus.arvalid = 1'b0;
                n++;
                if (bus.rvalid) begin
                    if (lat < 0) begin
                        lat  = n;
                        resp = bus.rresp;
                        data = bus.rdata;
                    end else if (bus.rresp !== resp || bus.rdata !== data) stable = 1'b0;
                    if (hold >= r_dly) begin
                        bus.rready = 1'b1;
                        ok = 1'b1;
                    end else hold++;
                end else if (lat >= 0) stable = 1'b0;
            end
            @(negedge clk);
            bus.rready = 1'b0;
        end else begin
            bus.arvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.cmd_valid, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 0000000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.cmd_valid, busy});
        end
        checks++;
        if ({bus.bresp, bus.rresp, bus.rdata, tcount, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata} !== 109'd0) begin
            errors++;
            $display("FAIL reset_values: rdata=%h tcount=%0d cmd_addr=%h cmd_wdata=%h expected all 0",
                     bus.rdata, tcount, bus.cmd_addr, bus.cmd_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        logic [1:0] resp;
        int lat;
        bit ok;
        int base = cmd_log.size();
        ctl_delay = 2;
        do_write(32'h100, 32'h1234_5678, 0, 0, 0, resp, lat, ok);
        ref_mem[32'h100] = 32'h1234_5678;
        checks++;
        if (ok !== 1'b1 || resp !== 2'b00) begin
            errors++;
            $display("FAIL write_basic_resp: ok=%0d bresp=%b expected ok=1 bresp=00", ok, resp);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL write_basic_latency: got %0d expected 4", lat);
        end
        checks++;
        if (cmd_log.size() !== base + 1) begin
            errors++;
            $display("FAIL write_basic_cmdcount: got %0d expected %0d", cmd_log.size() - base, 1);
        end else begin
            checks++;
            if (cmd_log[base].write !== 1'b1 || cmd_log[base].addr !== 23'h100 || cmd_log[base].wdata !== 32'h1234_5678) begin
                errors++;
                $display("FAIL write_basic_cmd: got w=%b a=%h d=%h expected w=1 a=000100 d=12345678",
                         cmd_log[base].write, cmd_log[base].addr, cmd_log[base].wdata);
            end
        end
        ctl_delay = 1;
    endtask

    task automatic test_read_basic();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok, stable;
        int base = cmd_log.size();
        ctl_force      = 1'b1;
        ctl_force_data = 32'hCAFE_F00D;
        do_read(32'h100, 0, 5, resp, data, lat, ok, stable);
        ctl_force = 1'b0;
        checks++;
        if (ok !== 1'b1 || resp !== 2'b00 || data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL read_basic: ok=%0d rresp=%b rdata=%h expected ok=1 rresp=00 rdata=cafef00d", ok, resp, data);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 3", lat);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL read_hold_stable: got %0d expected 1", stable);
        end
        checks++;
        if (cmd_log.size() !== base + 1 || cmd_log[base].write !== 1'b0 || cmd_log[base].addr !== 23'h100) begin
            errors++;
            $display("FAIL read_basic_cmd: count=%0d expected 1 read at 000100", cmd_log.size() - base);
        end
        do_read(32'h100, 1, 0, resp, data, lat, ok, stable);
        checks++;
        if (resp !== 2'b00 || data !== exp_rdata(32'h100)) begin
            errors++;
            $display("FAIL read_back: rresp=%b rdata=%h expected 00 %h", resp, data, exp_rdata(32'h100));
        end
    endtask

    task automatic test_write_order();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat, extra, base;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] addr = 32'h200 + 32'(4 * k);
            data = $urandom;
            base = cmd_log.size();
            if (k == 0) do_write(addr, data, 2, 0, 1, resp, lat, ok);
            else        do_write(addr, data, 0, 2, 1, resp, lat, ok);
            ref_mem[addr] = data;
            extra = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.bvalid) extra++;
            end
            checks++;
            if (ok !== 1'b1 || resp !== 2'b00 || extra !== 0) begin
                errors++;
                $display("FAIL write_order%0d_resp: ok=%0d bresp=%b extra_bvalid=%0d expected 1 00 0", k, ok, resp, extra);
            end
            checks++;
            if (cmd_log.size() !== base + 1) begin
                errors++;
                $display("FAIL write_order%0d_cmdcount: got %0d expected 1", k, cmd_log.size() - base);
            end else if (cmd_log[base].addr !== addr[22:0] || cmd_log[base].wdata !== data || cmd_log[base].write !== 1'b1) begin
                errors++;
                $display("FAIL write_order%0d_cmd: got a=%h d=%h expected a=%h d=%h",
                         k, cmd_log[base].addr, cmd_log[base].wdata, addr[22:0], data);
            end
        end
    endtask

    task automatic test_addr_errors();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok, stable;
        int base = cmd_log.size();
        do_read(32'h102, 0, 0, resp, data, lat, ok, stable);
        checks++;
        if (ok !== 1'b1 || resp !== 2'b10 || data !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL misaligned_read: rresp=%b rdata=%h lat=%0d expected 10 0 1", resp, data, lat);
        end
        do_write(32'h0080_0000, 32'h5555_AAAA, 0, 0, 0, resp, lat, ok);
        checks++;
        if (ok !== 1'b1 || resp !== 2'b11) begin
            errors++;
            $display("FAIL range_write: ok=%0d bresp=%b expected 1 11", ok, resp);
        end
        checks++;
        if (cmd_log.size() !== base) begin
            errors++;
            $display("FAIL addr_error_nocmd: got %0d commands expected 0", cmd_log.size() - base);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [31:0] addr, data, rdata;
            logic [1:0]  resp, er;
            int lat, cls, base;
            bit ok, stable, is_wr;
            cls = $urandom_range(0, 9);
            if (cls <= 6)      addr = 32'(4 * $urandom_range(0, 255));
            else if (cls == 7) addr = 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
            else if (cls == 8) addr = ($urandom | 32'h0080_0000) & 32'hFFFF_FFFC;
            else               addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 255));
            er = exp_resp(addr);
            is_wr = $urandom_range(0, 1) == 1;
            ctl_delay = $urandom_range(1, 3);
            base = cmd_log.size();
            if (is_wr) begin
                data = $urandom;
                do_write(addr, data, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, lat, ok);
                if (er == 2'b00) ref_mem[addr] = data;
                checks++;
                if (ok !== 1'b1 || resp !== er) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: addr=%h ok=%0d bresp=%b expected %b", it, addr, ok, resp, er);
                end
                checks++;
                if (cmd_log.size() !== base + (er == 2'b00 ? 1 : 0)) begin
                    errors++;
                    $display("FAIL rand_write_cmd[%0d]: addr=%h got %0d commands", it, addr, cmd_log.size() - base);
                end else if (er == 2'b00 && (cmd_log[base].addr !== addr[22:0] || cmd_log[base].wdata !== data)) begin
                    errors++;
                    $display("FAIL rand_write_cmd[%0d]: got a=%h d=%h expected a=%h d=%h",
                             it, cmd_log[base].addr, cmd_log[base].wdata, addr[22:0], data);
                end
            end else begin
                do_read(addr, $urandom_range(0, 3), $urandom_range(0, 2), resp, rdata, lat, ok, stable);
                data = (er == 2'b00) ? exp_rdata(addr) : 32'd0;
                checks++;
                if (ok !== 1'b1 || resp !== er || rdata !== data || stable !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: addr=%h rresp=%b rdata=%h expected %b %h", it, addr, resp, rdata, er, data);
                end
                checks++;
                if (cmd_log.size() !== base + (er == 2'b00 ? 1 : 0)) begin
                    errors++;
                    $display("FAIL rand_read_cmd[%0d]: addr=%h got %0d commands", it, addr, cmd_log.size() - base);
                end
            end
        end
        ctl_delay = 1;
    endtask

    task automatic test_fairness();
        int order[$];
        int cyc = 0;
        int base;
        // Reset while a command is stalled in front of the controller
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        bus.awaddr = 32'h40; bus.wdata = 32'h4040_4040;
        bus.awvalid = 1'b1;  bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;  bus.wvalid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_write !== 1'b1 || bus.cmd_addr !== 23'h40 || bus.cmd_wdata !== 32'h4040_4040) begin
            errors++;
            $display("FAIL cmd_hold: valid=%b write=%b addr=%h data=%h expected 1 1 000040 40404040",
                     bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.cmd_valid, busy, bus.bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_midflight: cmd_valid/busy/bvalid=%b expected 000", {bus.cmd_valid, busy, bus.bvalid});
        end
        reset = 1'b0;
        bus.cmd_ready = 1'b1;
        // All three valids held: grants must alternate starting with a write
        base = cmd_log.size();
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        while (order.size() < 4 && cyc < 200) begin
            @(negedge clk);
            bus.awaddr = 32'h1000 + 32'(16 * order.size());
            bus.wdata  = 32'hF000_0000 + 32'(order.size());
            bus.araddr = 32'h1000 + 32'(16 * order.size());
            bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
            #1;
            if (bus.awready && bus.wready) begin
                ref_mem[bus.awaddr] = bus.wdata;
                order.push_back(1);
            end else if (bus.arready) order.push_back(0);
            cyc++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        checks++;
        if (order.size() !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_count: grants=%0d busy=%b expected 4 0", order.size(), busy);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (order[k] !== ((k % 2 == 0) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got %0d expected %0d (1=W 0=R)", k, order[k], (k % 2 == 0) ? 1 : 0);
                end
            end
        end
        checks++;
        if (cmd_log.size() !== base + 4) begin
            errors++;
            $display("FAIL fair_cmds: got %0d expected 4", cmd_log.size() - base);
        end
    endtask

    task automatic test_timeout();
        logic [1:0]  resp;
        logic [31:0] data;
        int lat;
        bit ok, stable;
        int base = cmd_log.size();
        ctl_respond = 1'b0;
        do_read(32'h200, 0, 0, resp, data, lat, ok, stable);
        ctl_respond = 1'b1;
        checks++;
        if (ok !== 1'b1 || resp !== 2'b10 || data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL timeout_resp: ok=%0d rresp=%b rdata=%h expected 1 10 deadbeef", ok, resp, data);
        end
        checks++;
        if (lat !== 10 || tcount !== 16'd1 || cmd_log.size() !== base + 1) begin
            errors++;
            $display("FAIL timeout_count: lat=%0d count=%0d cmds=%0d expected 10 1 1", lat, tcount, cmd_log.size() - base);
        end
        // Bridge must refuse new work until the late completion is swallowed
        bus.araddr = 32'h7F0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.arvalid = 1'b1;
            #1;
            checks++;
            if (bus.arready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_blocks[%0d]: arready=%b busy=%b expected 0 0", k, bus.arready, busy);
            end
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        inject_req++;
        repeat (3) @(negedge clk);
        do_read(32'h7F0, 0, 0, resp, data, lat, ok, stable);
        checks++;
        if (ok !== 1'b1 || resp !== 2'b00 || data !== exp_rdata(32'h7F0) || tcount !== 16'd1) begin
            errors++;
            $display("FAIL after_drop_read: ok=%0d rresp=%b rdata=%h count=%0d expected 1 00 %h 1",
                     ok, resp, data, tcount, exp_rdata(32'h7F0));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.awaddr = 32'd0; bus.awvalid = 1'b0;
        bus.wdata  = 32'd0; bus.wvalid  = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = 32'd0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.cmd_ready = 1'b1;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_order();
        test_addr_errors();
        test_random();
        test_fairness();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyperram_axil_slave_bridge.md
Name: hyperram_axil_slave_bridge

Overview:
AXI4-Lite slave that terminates the 32-bit single-beat traffic generated by the HyperRAM AXI read/write tester and the CPU. It converts each accepted transaction into one word command on a simple valid/ready channel toward the HyperRAM controller, then returns the matching B or R response. Only one transaction is outstanding at a time. The bridge also provides address checking, a response timeout, and read/write fairness.

Parameters:
ADDR_BITS, 23, byte-address width decoded into cmd_addr; higher address bits must be zero.
TIMEOUT, 1023, max cycles in WAIT_RSP before the bridge gives up; range 1..65535.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
cmd_valid  out  1  command valid toward controller
cmd_ready  in  1  controller accepts command
cmd_write  out  1  1=write, 0=read
cmd_addr  out  ADDR_BITS  byte address, word aligned
cmd_wdata  out  32  write data
rsp_valid  in  1  controller completion pulse (reads and writes)
rsp_rdata  in  32  read data, valid with rsp_valid
busy  out  1  high whenever state != IDLE
timeout_count  out  16  saturating count of timed-out commands

Behaviour:
- Reset: state=IDLE; all ready/valid outputs 0; bresp=0, rresp=0, rdata=0, cmd_*=0; timeout_count=0; last_was_write=0; drop_rsp=0.
- States: IDLE, WCAP, CMD, WAIT_RSP, BRESP, RRESP.
- Grant in IDLE, combinational from valids:
  - Write wanted = awvalid|wvalid. Read wanted = arvalid.
  - Only one wanted: grant it.
  - Both wanted: grant the opposite of last_was_write.
- Ready signals:
  - awready = (IDLE & write granted) | (WCAP & ~aw_have).
  - wready = (IDLE & write granted) | (WCAP & ~w_have).
  - arready = IDLE & read granted.
- AW and W may arrive in any order or cycle. Capture each on its handshake. Stay in WCAP until both are held, then go to CMD. If both handshake in the same IDLE cycle, go directly to CMD.
- AR handshake: capture araddr and go to CMD. Set last_was_write on each grant.
- Address check on entry to CMD:
  - addr[1:0] != 0 gives SLVERR (2'b10).
  - Else any addr[31:ADDR_BITS] != 0 gives DECERR (2'b11).
  - On error, no command is issued; go straight to BRESP or RRESP (rdata=0).
- CMD: cmd_valid=1 with cmd_write/cmd_addr/cmd_wdata stable until the cycle cmd_ready=1. Then go to WAIT_RSP and clear the timer.
- WAIT_RSP:
  - rsp_valid: go to BRESP (bresp=OKAY), or to RRESP (rdata=rsp_rdata, rresp=OKAY).
  - Timer reaching TIMEOUT: respond SLVERR (rdata=32'hDEAD_BEEF on reads), increment timeout_count (saturate at 16'hFFFF), set drop_rsp.
- drop_rsp: the next rsp_valid received in any state is discarded and clears drop_rsp. While drop_rsp=1 the bridge does not leave IDLE.
- BRESP/RRESP: bvalid/rvalid held until bready/rready. Return to IDLE the cycle after the handshake.
- Latency with cmd_ready=1 and rsp_valid one cycle after cmd accept: AR handshake at cycle 0 gives rvalid at cycle 3. Same for AW+W at cycle 0 giving bvalid at cycle 3.
- rsp_valid outside WAIT_RSP with drop_rsp=0 is ignored.
- Reset mid-transaction: immediate return to reset values; any in-flight AXI transaction is abandoned.

Test Plan:
- Write awaddr=0x100, wdata=0x12345678 with awvalid&wvalid together; cmd_ready=1; rsp_valid 2 cycles later -> one cmd_valid pulse with cmd_write=1, cmd_addr=0x100, cmd_wdata=0x12345678; then bvalid with bresp=0.
- Read araddr=0x100; model returns rsp_rdata=0xCAFEF00D -> rvalid with rdata=0xCAFEF00D, rresp=0. With rready held low 5 cycles, rvalid/rdata stay stable.
- W two cycles before AW, and the reverse order -> single command with correct addr/data; exactly one bvalid.
- araddr=0x102 -> rresp=2'b10, no cmd_valid. awaddr=0x0080_0000 (ADDR_BITS=23) -> bresp=2'b11, no cmd_valid.
- awvalid, wvalid and arvalid held continuously for 4 transactions -> granted order W,R,W,R (last_was_write=0 after reset).
- TIMEOUT=8, read with no rsp_valid -> rresp=2'b10, rdata=0xDEADBEEF, timeout_count=1. A late rsp_valid is dropped, and the next read completes normally.
